// File: rtl/vec_pipe_sequencer.sv
// Vector pipeline sequencer: issues element indices 0..vl-1 of one instruction
// into a STAGES-deep segment pipeline and reports completion with a done pulse.
module vec_pipe_sequencer #(
  parameter int STAGES = 4,
  parameter int VL_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [VL_W-1:0]   instr_vl,
  output logic [STAGES-1:0] seg_en,
  output logic [STAGES-1:0] stage_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VL_W-1:0]   out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [VL_W-1:0] ONE = VL_W'(1);

  state_e            state_q, state_d;
  logic [VL_W-1:0]   vl_q, vl_d;
  logic [VL_W-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] last_q, last_d;
  logic [VL_W-1:0]   idx_q [STAGES];
  logic [VL_W-1:0]   idx_d [STAGES];
  logic              stall;
  logic              inject;
  logic              cnt_is_last;

  assign out_valid   = valid_q[STAGES-1];
  assign stall       = out_valid & ~out_ready;
  assign seg_en      = {STAGES{~stall}};
  assign stage_valid = valid_q;
  assign out_idx     = out_valid ? idx_q[STAGES-1] : '0;
  assign out_last    = out_valid & last_q[STAGES-1];
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign instr_ready = (state_q == IDLE) & ~flush;
  assign inject      = (state_q == ISSUE) & ~stall;
  assign cnt_is_last = (cnt_q == (vl_q - ONE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vl_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      last_q  <= '0;
      for (int i = 0; i < STAGES; i++) idx_q[i] <= '0;
    end else begin
      state_q <= state_d;
      vl_q    <= vl_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      for (int i = 0; i < STAGES; i++) idx_q[i] <= idx_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    vl_d    = vl_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    last_d  = last_q;
    idx_d   = idx_q;

    // The whole pipeline moves together; a stall freezes every segment.
    if (!stall) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        last_d[i]  = last_q[i-1];
        idx_d[i]   = idx_q[i-1];
      end
      valid_d[0] = inject;
      last_d[0]  = inject & cnt_is_last;
      idx_d[0]   = cnt_q;
    end

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          vl_d  = instr_vl;
          cnt_d = '0;
          if (instr_vl != '0) state_d = ISSUE;
          else                done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (inject) begin
          cnt_d = cnt_q + ONE;
          if (cnt_is_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any transition or completion in the same cycle.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      valid_d = '0;
      last_d  = '0;
    end
  end

endmodule

// File: tb/tb_vec_pipe_sequencer.sv
// Bench for vec_pipe_sequencer: a cycle table for the documented timing, then
// directed corner cases and random traffic against an element-queue scoreboard.
module tb_vec_pipe_sequencer;

  localparam int STAGES = 4;
  localparam int VL_W   = 8;

  logic              clk = 1'b0;
  logic              reset, flush, instr_valid, out_ready;
  logic [VL_W-1:0]   instr_vl;
  logic              instr_ready, out_valid, out_last, busy, done;
  logic [STAGES-1:0] seg_en, stage_valid;
  logic [VL_W-1:0]   out_idx;

  vec_pipe_sequencer #(.STAGES(STAGES), .VL_W(VL_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_vl(instr_vl),
    .seg_en(seg_en), .stage_valid(stage_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fl, iv;
    logic [VL_W-1:0] vl;
    logic ordy;
    logic eIr, eBusy, eOv;
    logic [VL_W-1:0] eIdx;
    logic eLast, eDone;
    logic [STAGES-1:0] eSv;
  } vec_t;

  vec_t tbl[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cycle      = 0;

  // Scoreboard: the element indices still owed by the accepted instruction.
  int   expQ[$];
  int   seenLog[$];
  int   curVl = 0;
  bit   inflight = 0;
  bit   doneExp = 0;
  bit   doneSeen = 0;
  bit   firstPending = 0;
  int   acceptCycle = 0;

  function automatic vec_t mk(logic rst, logic fl, logic iv, int vl, logic ordy,
                              logic eIr, logic eBusy, logic eOv, int eIdx,
                              logic eLast, logic eDone, logic [STAGES-1:0] eSv);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.vl = VL_W'(vl); v.ordy = ordy;
    v.eIr = eIr; v.eBusy = eBusy; v.eOv = eOv; v.eIdx = VL_W'(eIdx);
    v.eLast = eLast; v.eDone = eDone; v.eSv = eSv;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (cycle %0d): got %0d expected %0d", name, cycle, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; flush = v.fl; instr_valid = v.iv; instr_vl = v.vl; out_ready = v.ordy;
  endtask

  task automatic runRow(input vec_t v);
    applyStimulus(v);
    @(negedge clk);
    checkOutput("tbl instr_ready", instr_ready, v.eIr);
    checkOutput("tbl busy", busy, v.eBusy);
    checkOutput("tbl out_valid", out_valid, v.eOv);
    checkOutput("tbl out_idx", out_idx, v.eIdx);
    checkOutput("tbl out_last", out_last, v.eLast);
    checkOutput("tbl done", done, v.eDone);
    checkOutput("tbl stage_valid", stage_valid, v.eSv);
    @(posedge clk); #1; cycle++;
  endtask

  task automatic checkModel();
    logic [STAGES-1:0] expEn;
    expEn = (out_valid && !out_ready) ? '0 : {STAGES{1'b1}};
    checkOutput("busy", busy, inflight);
    checkOutput("instr_ready", instr_ready, !inflight && !flush);
    checkOutput("done", done, doneExp);
    checkOutput("seg_en", seg_en, expEn);
    if (done) doneSeen = 1;
    if (out_valid) begin
      if (expQ.size() == 0) checkOutput("unexpected out_valid", out_valid, 0);
      else begin
        checkOutput("out_idx", out_idx, expQ[0]);
        checkOutput("out_last", out_last, expQ[0] == curVl - 1);
        if (firstPending) begin
          checkOutput("first output latency", cycle, acceptCycle + 1 + STAGES);
          firstPending = 0;
        end
      end
    end else begin
      checkOutput("idle out_idx", out_idx, 0);
      checkOutput("idle out_last", out_last, 0);
    end
  endtask

  task automatic modelUpdate();
    bit was = inflight;
    bit dn = 0;
    if (reset || flush) begin
      expQ.delete(); inflight = 0; doneExp = 0; firstPending = 0;
      return;
    end
    if (out_valid && out_ready && expQ.size() > 0) begin
      seenLog.push_back(int'(out_idx));
      if (expQ[0] == curVl - 1) begin inflight = 0; dn = 1; end
      void'(expQ.pop_front());
    end
    if (instr_valid && !was) begin
      if (instr_vl == 0) dn = 1;
      else begin
        curVl = int'(instr_vl);
        for (int k = 0; k < curVl; k++) expQ.push_back(k);
        inflight = 1; acceptCycle = cycle; firstPending = 1;
      end
    end
    doneExp = dn;
  endtask

  task automatic step();
    @(negedge clk);
    checkModel();
    modelUpdate();
    @(posedge clk); #1; cycle++;
  endtask

  task automatic runUntilDone(input int budget, input bit randReady);
    doneSeen = 0;
    for (int k = 0; k < budget && !doneSeen; k++) begin
      out_ready = randReady ? ($urandom % 4 != 0) : 1'b1;
      step();
    end
    checkOutput("done within budget", doneSeen, 1);
  endtask

  initial begin
    int expSeq[5] = '{0, 1, 2, 0, 1};
    bit accepted2;

    reset = 1; flush = 0; instr_valid = 0; instr_vl = '0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1; reset = 0;

    // rst fl iv vl rdy | ir busy ov idx last done stage_valid
    tbl.push_back(mk(0,0,1,5,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0011));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0111));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,0,0,0,4'b1111));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,1,0,0,4'b1111));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,2,0,0,4'b1110));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,3,0,0,4'b1100));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,4,1,0,4'b1000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,1,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,1,0,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,1,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,1,3,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0000));
    tbl.push_back(mk(1,0,0,0,1,  0,1,0,0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,1,10,1, 1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0011));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0111));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,0,0,0,4'b1111));
    tbl.push_back(mk(0,1,1,1,1,  0,1,1,1,0,0,4'b1111));
    tbl.push_back(mk(0,0,1,1,1,  1,0,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0001));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,1,  0,1,0,0,0,0,4'b0100));
    tbl.push_back(mk(0,0,0,0,1,  0,1,1,0,1,0,4'b1000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,1,4'b0000));
    tbl.push_back(mk(0,0,0,0,1,  1,0,0,0,0,0,4'b0000));
    foreach (tbl[i]) runRow(tbl[i]);

    reset = 1; flush = 0; instr_valid = 0; out_ready = 1;
    step();
    reset = 0;

    // Backpressure for three cycles while the pipeline is draining vl=6.
    cycle = 0;
    instr_valid = 1; instr_vl = 8'd6; step();
    instr_valid = 0;
    for (int c = 1; c <= 14; c++) begin
      out_ready = !(c >= 7 && c <= 9);
      #1;
      if (c >= 7 && c <= 9) begin
        checkOutput("stall seg_en", seg_en, 0);
        checkOutput("stall holds idx", out_idx, 2);
      end
      if (c == 11) checkOutput("stall done not early", done, 0);
      if (c == 14) checkOutput("stall done delayed", done, 1);
      step();
    end
    out_ready = 1;

    // Second instruction held on the bus must slip in exactly in the done cycle.
    seenLog.delete();
    accepted2 = 0;
    instr_valid = 1; instr_vl = 8'd3; step();
    instr_vl = 8'd2;
    for (int k = 0; k < 40 && !accepted2; k++) begin
      #1;
      if (instr_ready) begin
        checkOutput("b2b accept in done cycle", done, 1);
        accepted2 = 1;
      end
      step();
    end
    checkOutput("b2b second accepted", accepted2, 1);
    instr_valid = 0;
    runUntilDone(40, 0);
    checkOutput("b2b output count", seenLog.size(), 5);
    for (int i = 0; i < 5 && i < seenLog.size(); i++)
      checkOutput("b2b output idx", seenLog[i], expSeq[i]);

    // Longest instruction with random backpressure: no counter wrap.
    seenLog.delete();
    instr_valid = 1; instr_vl = 8'd255; step();
    instr_valid = 0;
    runUntilDone(2000, 1);
    checkOutput("vl255 output count", seenLog.size(), 255);
    if (seenLog.size() > 0) checkOutput("vl255 final idx", seenLog[seenLog.size()-1], 254);
    out_ready = 1;

    // Reset in mid-stream returns every output to its reset value.
    instr_valid = 1; instr_vl = 8'd255; step();
    instr_valid = 0;
    repeat (60) step();
    reset = 1; step();
    reset = 0; out_ready = 0;
    #1;
    checkOutput("reset instr_ready", instr_ready, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_idx", out_idx, 0);
    checkOutput("reset out_last", out_last, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset stage_valid", stage_valid, 0);
    checkOutput("reset seg_en", seg_en, {STAGES{1'b1}});
    out_ready = 1;
    step();

    // Random traffic including occasional flushes.
    for (int k = 0; k < 600; k++) begin
      flush       = ($urandom % 40 == 0);
      instr_valid = ($urandom % 3 == 0);
      instr_vl    = VL_W'($urandom_range(0, 9));
      out_ready   = ($urandom % 4 != 0);
      step();
    end
    flush = 0; instr_valid = 0; out_ready = 1;
    for (int k = 0; k < 300 && inflight; k++) step();
    checkOutput("random drain idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
